// File: rtl/stream_mux_4to1_rr_pkg.sv
// Shared types and constants for the comsys stream-merge datapath.
package comsys_pkg;
    localparam int DATA_W = 5;
    localparam int NUM_CH = 4;

    typedef logic [1:0] chan_idx_t;

    typedef enum logic {
        IDLE,
        LOCKED
    } arb_state_t;
endpackage

// File: rtl/stream_mux_4to1_rr_if.sv
// Four-channel input streams plus the merged output stream of the 4:1 mux.
interface stream_mux_4to1_rr_if
    import comsys_pkg::*;
#(
    parameter int DATA_W = comsys_pkg::DATA_W
);
    logic [NUM_CH-1:0] chan_en;
    logic [NUM_CH-1:0] in_valid;
    logic [DATA_W-1:0] in_data0;
    logic [DATA_W-1:0] in_data1;
    logic [DATA_W-1:0] in_data2;
    logic [DATA_W-1:0] in_data3;
    logic [NUM_CH-1:0] in_ready;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    chan_idx_t         out_sel;
    logic              out_ready;

    modport slave (
        input  chan_en, in_valid, in_data0, in_data1, in_data2, in_data3, out_ready,
        output in_ready, out_valid, out_data, out_sel
    );

    modport master (
        output chan_en, in_valid, in_data0, in_data1, in_data2, in_data3, out_ready,
        input  in_ready, out_valid, out_data, out_sel
    );
endinterface

// File: rtl/stream_mux_4to1_rr_pick.sv
// Combinational rotating-priority picker: first requester after 'last', wrapping.
module rr_pick4
    import comsys_pkg::*;
(
    input  logic [NUM_CH-1:0] req,
    input  chan_idx_t         last,
    output logic              gnt_valid,
    output chan_idx_t         gnt_idx
);
    chan_idx_t         cand [NUM_CH];
    logic [NUM_CH-1:0] cand_req;

    // cand[gi] is the channel at priority rank gi (rank 0 = last+1, rank 3 = last)
    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_cand
            assign cand[gi]     = last + chan_idx_t'(gi + 1);
            assign cand_req[gi] = req[cand[gi]];
        end
    endgenerate

    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = last;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            if (cand_req[k]) begin
                gnt_valid = 1'b1;
                gnt_idx   = cand[k];
            end
        end
    end
endmodule

// File: rtl/stream_mux_4to1_rr.sv
// 4:1 valid/ready stream merge with round-robin grant, burst lock and a registered output beat.
module stream_mux_4to1_rr
    import comsys_pkg::*;
#(
    parameter int DATA_W    = comsys_pkg::DATA_W,
    parameter int BURST_LEN = 1
)(
    input  logic                 clk,
    input  logic                 rst_n,
    stream_mux_4to1_rr_if.slave  bus
);
    localparam logic [3:0] BURST_CNT = 4'(BURST_LEN);

    arb_state_t        state_reg, state_next;
    chan_idx_t         owner_reg, owner_next;
    chan_idx_t         last_grant_reg, last_grant_next;
    logic [3:0]        beat_cnt_reg, beat_cnt_next;

    logic              out_valid_reg;
    logic [DATA_W-1:0] out_data_reg;
    chan_idx_t         out_sel_reg;

    logic [NUM_CH-1:0] req;
    logic [DATA_W-1:0] data_arr [NUM_CH];
    logic              load_en;
    logic              lock_hit;
    logic              pick_valid;
    chan_idx_t         pick_idx;
    chan_idx_t         search_last;
    logic              grant_valid;
    chan_idx_t         grant;
    logic              xfer;

    assign data_arr[0] = bus.in_data0;
    assign data_arr[1] = bus.in_data1;
    assign data_arr[2] = bus.in_data2;
    assign data_arr[3] = bus.in_data3;

    assign req     = bus.in_valid & bus.chan_en;
    assign load_en = !out_valid_reg || bus.out_ready;

    // A locked owner that drops out releases and the search restarts after it in the same cycle.
    assign lock_hit    = (state_reg == LOCKED) && req[owner_reg];
    assign search_last = (state_reg == LOCKED) ? owner_reg : last_grant_reg;

    rr_pick4 u_pick (
        .req       (req),
        .last      (search_last),
        .gnt_valid (pick_valid),
        .gnt_idx   (pick_idx)
    );

    assign grant_valid = lock_hit || pick_valid;
    assign grant       = lock_hit ? owner_reg : pick_idx;
    assign xfer        = rst_n && load_en && grant_valid;

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ready
            assign bus.in_ready[gi] = xfer && (grant == chan_idx_t'(gi));
        end
    endgenerate

    always_comb begin
        state_next      = state_reg;
        owner_next      = owner_reg;
        last_grant_next = last_grant_reg;
        beat_cnt_next   = beat_cnt_reg;
        if (load_en) begin
            if (lock_hit) begin
                if (beat_cnt_reg + 4'd1 == BURST_CNT) begin
                    state_next      = IDLE;
                    last_grant_next = owner_reg;
                    beat_cnt_next   = 4'd0;
                end else begin
                    beat_cnt_next = beat_cnt_reg + 4'd1;
                end
            end else begin
                if (state_reg == LOCKED) begin
                    state_next      = IDLE;
                    last_grant_next = owner_reg;
                    beat_cnt_next   = 4'd0;
                end
                if (pick_valid) begin
                    owner_next = pick_idx;
                    if (BURST_CNT == 4'd1) begin
                        state_next      = IDLE;
                        last_grant_next = pick_idx;
                        beat_cnt_next   = 4'd0;
                    end else begin
                        state_next    = LOCKED;
                        beat_cnt_next = 4'd1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            owner_reg      <= '0;
            last_grant_reg <= chan_idx_t'(NUM_CH - 1);
            beat_cnt_reg   <= '0;
        end else begin
            state_reg      <= state_next;
            owner_reg      <= owner_next;
            last_grant_reg <= last_grant_next;
            beat_cnt_reg   <= beat_cnt_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
            out_sel_reg   <= '0;
        end else if (load_en) begin
            out_valid_reg <= xfer;
            if (xfer) begin
                out_data_reg <= data_arr[grant];
                out_sel_reg  <= grant;
            end
        end
    end

    assign bus.out_valid = out_valid_reg;
    assign bus.out_data  = out_data_reg;
    assign bus.out_sel   = out_sel_reg;
endmodule
